// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle MIPS-subset datapath: one instruction phase per state,
// shared instruction/data memory port with req/ready handshake, retired-instruction counter.
module multicycle_controller #(
  parameter logic [4:0] ALU_AND = 5'b00000,
  parameter logic [4:0] ALU_OR  = 5'b00001,
  parameter logic [4:0] ALU_ADD = 5'b00010,
  parameter logic [4:0] ALU_SUB = 5'b00110,
  parameter logic [4:0] ALU_SLT = 5'b00111
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        memReady,
  output logic        memReq,
  output logic        memWrite,
  output logic        iOrD,
  output logic        irWrite,
  output logic        pcWrite,
  output logic [1:0]  pcSrc,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [4:0]  aluControl,
  output logic        regWrite,
  output logic [1:0]  regDst,
  output logic [1:0]  memToReg,
  output logic        illegal,
  output logic [31:0] retired,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    RESET_S = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  MEMADR  = 4'd3,
    MEMRD   = 4'd4,  MEMWB  = 4'd5,  MEMWR  = 4'd6,  EXECUTE = 4'd7,
    ALUWB   = 4'd8,  BRANCH = 4'd9,  ADDIEX = 4'd10, ADDIWB  = 4'd11,
    JUMP    = 4'd12, JAL    = 4'd13, JR     = 4'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  state_e      state_q, state_d;
  logic [31:0] retired_q, retired_d;
  logic        retire;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RESET_S;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // NOTE: every comb output gets a default up front so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      RESET_S: state_d = FETCH;
      FETCH:   if (memReady) state_d = DECODE;
      DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = (funct == FN_JR) ? JR : EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          OP_JAL:       state_d = JAL;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   if (memReady) state_d = MEMWB;
      MEMWR: begin
        if (memReady) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      EXECUTE: begin
        unique case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: state_d = ALUWB;
          default:                               state_d = FETCH;
        endcase
      end
      ADDIEX:  state_d = ADDIWB;
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP, JAL, JR: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  assign retired_d = retire ? retired_q + 32'd1 : retired_q;

  always_comb begin
    memReq     = 1'b0;
    memWrite   = 1'b0;
    iOrD       = 1'b0;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    pcSrc      = 2'd0;
    aluSrcA    = 1'b0;
    aluSrcB    = 2'd0;
    aluControl = ALU_ADD;
    regWrite   = 1'b0;
    regDst     = 2'd0;
    memToReg   = 2'd0;
    illegal    = 1'b0;
    unique case (state_q)
      RESET_S: aluControl = 5'd0;
      FETCH: begin
        memReq  = 1'b1;
        aluSrcB = 2'd1;
        irWrite = memReady;
        pcWrite = memReady;
      end
      DECODE: begin
        aluSrcB = 2'd3;
        unique case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J, OP_JAL: illegal = 1'b0;
          default:                                               illegal = 1'b1;
        endcase
      end
      MEMADR, ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'd2;
      end
      MEMRD: begin
        memReq = 1'b1;
        iOrD   = 1'b1;
      end
      MEMWB: begin
        regWrite = 1'b1;
        memToReg = 2'd1;
      end
      MEMWR: begin
        memReq   = 1'b1;
        memWrite = 1'b1;
        iOrD     = 1'b1;
      end
      EXECUTE: begin
        aluSrcA = 1'b1;
        unique case (funct)
          FN_ADD:  aluControl = ALU_ADD;
          FN_SUB:  aluControl = ALU_SUB;
          FN_AND:  aluControl = ALU_AND;
          FN_OR:   aluControl = ALU_OR;
          FN_SLT:  aluControl = ALU_SLT;
          default: illegal    = 1'b1;
        endcase
      end
      ALUWB: begin
        regWrite = 1'b1;
        regDst   = 2'd1;
      end
      BRANCH: begin
        aluSrcA    = 1'b1;
        aluControl = ALU_SUB;
        pcSrc      = 2'd1;
        pcWrite    = zero;
      end
      ADDIWB:  regWrite = 1'b1;
      JUMP: begin
        pcSrc   = 2'd2;
        pcWrite = 1'b1;
      end
      JAL: begin
        pcSrc    = 2'd2;
        pcWrite  = 1'b1;
        regWrite = 1'b1;
        regDst   = 2'd2;
        memToReg = 2'd2;
      end
      JR: begin
        pcSrc   = 2'd3;
        pcWrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction phase model built from the instruction
// class, random opcodes/functs/wait states, plus directed reset and illegal cases.
module tb_multicycle_controller;

  localparam logic [4:0] A_AND = 5'b00000, A_OR = 5'b00001, A_ADD = 5'b00010,
                         A_SUB = 5'b00110, A_SLT = 5'b00111;

  logic        clock = 1'b0, reset_n = 1'b0;
  logic [5:0]  opcode = '0, funct = '0;
  logic        zero = 1'b0, memReady = 1'b0;
  logic        memReq, memWrite, iOrD, irWrite, pcWrite, aluSrcA, regWrite, illegal;
  logic [1:0]  pcSrc, aluSrcB, regDst, memToReg;
  logic [4:0]  aluControl;
  logic [31:0] retired;
  logic [3:0]  state;

  int n_tests = 0, n_fail = 0;
  logic [31:0] exp_ret = '0;

  typedef struct packed {
    logic [3:0] st;
    logic       req, wr, iord, irw, pcw;
    logic [1:0] pcsrc;
    logic       srca;
    logic [1:0] srcb;
    logic [4:0] alu;
    logic       rw;
    logic [1:0] rdst, m2r;
    logic       ill;
  } exp_t;

  multicycle_controller dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .memReady(memReady), .memReq(memReq), .memWrite(memWrite), .iOrD(iOrD),
    .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .aluControl(aluControl), .regWrite(regWrite), .regDst(regDst),
    .memToReg(memToReg), .illegal(illegal), .retired(retired), .state(state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_outs();
    exp_t o;
    o = '{state, memReq, memWrite, iOrD, irWrite, pcWrite, pcSrc, aluSrcA, aluSrcB,
          aluControl, regWrite, regDst, memToReg, illegal};
    return 32'(o);
  endfunction

  function automatic exp_t mk(input logic [3:0] st);
    exp_t e;
    e = '0;
    e.st  = st;
    e.alu = A_ADD;
    return e;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Called at posedge+1: drive memReady, compare at the falling edge, advance one cycle.
  task automatic cyc(input logic rdy, input exp_t e, input string tag);
    memReady = rdy;
    @(negedge clock);
    check(tag, dut_outs(), 32'(e));
    @(posedge clock);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int wf, input int wm);
    exp_t e;
    logic legal_op;
    logic [4:0] alu;
    logic fn_ok;
    opcode = op;
    funct  = fn;
    zero   = z;
    check("retired_at_fetch", retired, exp_ret);
    e = mk(4'd1);
    e.req  = 1'b1;
    e.srcb = 2'd1;
    for (int i = 0; i < wf; i++) cyc(1'b0, e, "fetch_wait");
    e.irw = 1'b1;
    e.pcw = 1'b1;
    cyc(1'b1, e, "fetch_ready");

    legal_op = (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                           6'b000010, 6'b000011});
    e = mk(4'd2);
    e.srcb = 2'd3;
    e.ill  = !legal_op;
    cyc(rnd(), e, "decode");
    if (!legal_op) return;

    case (op)
      6'b100011, 6'b101011: begin
        e = mk(4'd3); e.srca = 1'b1; e.srcb = 2'd2;
        cyc(rnd(), e, "memadr");
        if (op == 6'b100011) begin
          e = mk(4'd4); e.req = 1'b1; e.iord = 1'b1;
          for (int i = 0; i < wm; i++) cyc(1'b0, e, "memrd_wait");
          cyc(1'b1, e, "memrd_ready");
          e = mk(4'd5); e.rw = 1'b1; e.m2r = 2'd1;
          cyc(rnd(), e, "memwb");
        end else begin
          e = mk(4'd6); e.req = 1'b1; e.wr = 1'b1; e.iord = 1'b1;
          for (int i = 0; i < wm; i++) cyc(1'b0, e, "memwr_wait");
          cyc(1'b1, e, "memwr_ready");
        end
        exp_ret++;
      end
      6'b000000: begin
        if (fn == 6'b001000) begin
          e = mk(4'd14); e.pcsrc = 2'd3; e.pcw = 1'b1;
          cyc(rnd(), e, "jr");
          exp_ret++;
        end else begin
          fn_ok = 1'b1;
          case (fn)
            6'b100000: alu = A_ADD;
            6'b100010: alu = A_SUB;
            6'b100100: alu = A_AND;
            6'b100101: alu = A_OR;
            6'b101010: alu = A_SLT;
            default: begin alu = A_ADD; fn_ok = 1'b0; end
          endcase
          e = mk(4'd7); e.srca = 1'b1; e.alu = alu; e.ill = !fn_ok;
          cyc(rnd(), e, "execute");
          if (fn_ok) begin
            e = mk(4'd8); e.rw = 1'b1; e.rdst = 2'd1;
            cyc(rnd(), e, "aluwb");
            exp_ret++;
          end
        end
      end
      6'b000100: begin
        e = mk(4'd9); e.srca = 1'b1; e.alu = A_SUB; e.pcsrc = 2'd1; e.pcw = z;
        cyc(rnd(), e, "branch");
        exp_ret++;
      end
      6'b001000: begin
        e = mk(4'd10); e.srca = 1'b1; e.srcb = 2'd2;
        cyc(rnd(), e, "addiex");
        e = mk(4'd11); e.rw = 1'b1;
        cyc(rnd(), e, "addiwb");
        exp_ret++;
      end
      6'b000010: begin
        e = mk(4'd12); e.pcsrc = 2'd2; e.pcw = 1'b1;
        cyc(rnd(), e, "jump");
        exp_ret++;
      end
      default: begin
        e = mk(4'd13); e.pcsrc = 2'd2; e.pcw = 1'b1; e.rw = 1'b1; e.rdst = 2'd2; e.m2r = 2'd2;
        cyc(rnd(), e, "jal");
        exp_ret++;
      end
    endcase
  endtask

  initial begin
    logic [5:0] op, fn;
    exp_t e;
    int k;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", dut_outs(), 32'd0);
    check("reset_retired", retired, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    run_instr(6'b100011, 6'b000000, 1'b0, 2, 2);
    check("retired_after_lw", retired, 32'd1);
    run_instr(6'b000000, 6'b100010, 1'b0, 0, 0);
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
    run_instr(6'b000100, 6'b000000, 1'b0, 1, 0);
    run_instr(6'b000011, 6'b000000, 1'b0, 0, 0);
    run_instr(6'b000000, 6'b001000, 1'b0, 0, 0);
    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
    run_instr(6'b000000, 6'b000001, 1'b0, 0, 0);
    run_instr(6'b101011, 6'b000000, 1'b1, 0, 3);

    for (int n = 0; n < 200; n++) begin
      k  = $urandom_range(0, 8);
      fn = 6'($urandom);
      case (k)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: begin
          op = 6'b000000;
          case ($urandom_range(0, 6))
            0: fn = 6'b100000;
            1: fn = 6'b100010;
            2: fn = 6'b100100;
            3: fn = 6'b100101;
            4: fn = 6'b101010;
            5: fn = 6'b001000;
            default: ;
          endcase
        end
        3: op = 6'b000100;
        4: op = 6'b001000;
        5: op = 6'b000010;
        6: op = 6'b000011;
        default: begin
          op = 6'($urandom);
          while (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                            6'b000010, 6'b000011}) op = 6'($urandom);
        end
      endcase
      run_instr(op, fn, rnd(), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    check("retired_after_random", retired, exp_ret);

    // Asynchronous reset in the middle of a store's memory wait.
    opcode = 6'b101011;
    funct  = 6'b000000;
    e = mk(4'd1); e.req = 1'b1; e.srcb = 2'd1; e.irw = 1'b1; e.pcw = 1'b1;
    cyc(1'b1, e, "rst_fetch");
    e = mk(4'd2); e.srcb = 2'd3;
    cyc(1'b0, e, "rst_decode");
    e = mk(4'd3); e.srca = 1'b1; e.srcb = 2'd2;
    cyc(1'b0, e, "rst_memadr");
    e = mk(4'd6); e.req = 1'b1; e.wr = 1'b1; e.iord = 1'b1;
    memReady = 1'b0;
    @(negedge clock);
    check("memwr_before_reset", dut_outs(), 32'(e));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", dut_outs(), 32'd0);
    check("async_reset_retired", retired, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("fetch_after_release", 32'(state), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore/Mealy control FSM that sequences a multicycle MIPS-subset datapath built from the existing ALU, register file, PC register and mux blocks.
- Instruction and data share one memory port with a req/ready handshake.
- The controller drives every datapath select and enable, one instruction phase per state.
- It also counts retired instructions and flags illegal encodings.

Parameters:
ALU_AND, 5'b00000, aluControl code for AND
ALU_OR, 5'b00001, aluControl code for OR
ALU_ADD, 5'b00010, aluControl code for ADD
ALU_SUB, 5'b00110, aluControl code for SUB
ALU_SLT, 5'b00111, aluControl code for set-less-than

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
opcode  input  6  instr[31:26] from instruction register
funct  input  6  instr[5:0] from instruction register
zero  input  1  ALU zero flag, same cycle
memReady  input  1  memory completes the access this cycle
memReq  output  1  memory access request
memWrite  output  1  access is a write (valid only with memReq)
iOrD  output  1  address select: 0 = PC, 1 = ALUOut
irWrite  output  1  load instruction register
pcWrite  output  1  load PC
pcSrc  output  2  0 = ALUResult, 1 = ALUOut, 2 = {pc[31:28],instr[25:0],2'b0}, 3 = RD1 (rs)
aluSrcA  output  1  0 = PC, 1 = register A
aluSrcB  output  2  0 = register B, 1 = constant 4, 2 = SignImm, 3 = SignImm<<2
aluControl  output  5  ALU operation code
regWrite  output  1  register-file write enable
regDst  output  2  0 = rt, 1 = rd, 2 = r31
memToReg  output  2  0 = ALUOut, 1 = MDR, 2 = PC
illegal  output  1  one-cycle pulse on an unsupported opcode or funct
retired  output  32  count of completed instructions
state  output  4  current state, for debug

Behaviour:
- Reset: reset_n low forces state to RESET_S (0) asynchronously, including mid-instruction.
  - In RESET_S, all outputs are 0 and retired is 0.
  - The first edge after reset_n goes high moves the FSM to FETCH.
- Outputs not listed for a state are 0. aluControl defaults to ALU_ADD.
- State encodings: RESET_S 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXECUTE 7, ALUWB 8, BRANCH 9, ADDIEX 10, ADDIWB 11, JUMP 12, JAL 13, JR 14. Code 15 is unreachable; if entered, go to FETCH.
- FETCH: memReq=1, iOrD=0, aluSrcA=0, aluSrcB=1, ADD, pcSrc=0.
  - irWrite and pcWrite equal memReady (Mealy).
  - Stay in FETCH while memReady=0; on memReady=1 go to DECODE.
- DECODE: aluSrcA=0, aluSrcB=3, ADD (precomputes the branch target). Next state by opcode:
  - 100011 or 101011 → MEMADR
  - 000000 with funct 001000 → JR
  - 000000 with any other funct → EXECUTE
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - 000011 → JAL
  - any other opcode → FETCH with illegal=1
- MEMADR: aluSrcA=1, aluSrcB=2, ADD. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: memReq=1, iOrD=1. Wait for memReady, then go to MEMWB.
- MEMWB: regWrite=1, regDst=0, memToReg=1 → FETCH.
- MEMWR: memReq=1, memWrite=1, iOrD=1. Wait for memReady, then go to FETCH.
- EXECUTE: aluSrcA=1, aluSrcB=0.
  - funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT → ALUWB.
  - Other funct → FETCH with illegal=1.
- ALUWB: regWrite=1, regDst=1, memToReg=0 → FETCH.
- BRANCH: aluSrcA=1, aluSrcB=0, SUB, pcSrc=1, pcWrite=zero → FETCH.
- ADDIEX: aluSrcA=1, aluSrcB=2, ADD → ADDIWB.
- ADDIWB: regWrite=1, regDst=0, memToReg=0 → FETCH.
- JUMP: pcSrc=2, pcWrite=1 → FETCH.
- JAL: pcSrc=2, pcWrite=1, regWrite=1, regDst=2, memToReg=2 → FETCH. r31 receives the pre-edge PC, which is already PC+4.
- JR: pcSrc=3, pcWrite=1 → FETCH.
- retired: increments by 1, wrapping at 2^32, on each transition into FETCH from MEMWB, MEMWR (on memReady), ALUWB, BRANCH, ADDIWB, JUMP, JAL or JR.
  - It does not increment on entries from RESET_S or on illegal paths.
- Handshake rules:
  - memReady is ignored when memReq=0.
  - memReq, iOrD and memWrite stay stable for the whole wait.
  - No timeout.
- Cycle counts with zero-wait memory: lw 5, sw 4, R-type 4, addi 4, beq 3, j/jal/jr 3.

Test Plan:
- Reset, then lw (opcode 100011) with memReady delayed 2 cycles in both FETCH and MEMRD → state sequence 1,1,1,2,3,4,4,4,5,1; irWrite/pcWrite high only in the FETCH ready cycle; regWrite=1 with memToReg=1 in MEMWB; retired=1.
- R-type funct 100010 → EXECUTE shows aluControl=00110, aluSrcB=0; ALUWB shows regDst=1, regWrite=1; 4 cycles total.
- beq with zero=1, then beq with zero=0 → in BRANCH, pcWrite=1 and pcSrc=1 the first time, pcWrite=0 the second; retired increments by 1 both times.
- jal, then jr (funct 001000) → JAL shows pcSrc=2, regDst=2, memToReg=2, regWrite=1; JR shows pcSrc=3, pcWrite=1, regWrite=0.
- Opcode 111111, then R-type funct 000001 → illegal pulses 1 cycle in DECODE and in EXECUTE respectively; FSM returns to FETCH; retired unchanged.
- Assert reset_n=0 mid-MEMWR while memReq=1 → memReq and memWrite drop to 0 immediately, without waiting for a clock edge; state=0; retired=0; after release, next edge enters FETCH.
